// File: rtl/o_detect_pkg.sv
// ============================================================================
// Module : o_detect_pkg
// Brief  : Shared state encodings and width helpers for the detector scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package o_detect_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLEAR = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_RESP  = 3'd4;

   function automatic int id_width(input int n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

   function automatic int cnt_width(input int word_w);
      return $clog2(word_w + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin pick: first request at or above the pointer, wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [ID_W-1:0]  idx_o,
   output logic             any_o
);

   logic [ID_W:0]   w_sum;
   logic [ID_W-1:0] w_pos;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      w_sum   = '0;
      w_pos   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_sum = {1'b0, ptr_i} + (ID_W+1)'(i);
         if (w_sum >= (ID_W+1)'(N_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(N_REQ);
         end
         w_pos = w_sum[ID_W-1:0];
         if (!any_o && req_i[w_pos]) begin
            grant_o[w_pos] = 1'b1;
            idx_o          = w_pos;
            any_o          = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/o_detect_sched.sv
// ============================================================================
// Module : o_detect_sched
// Brief  : Time-shares one serial 0111 detector between round-robin requesters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module o_detect_sched
   import o_detect_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int WORD_W = 16,
   parameter int ID_W   = id_width(N_REQ),
   parameter int CNT_W  = cnt_width(WORD_W)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*WORD_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    det_rst,
   output logic                    det_in,
   input  logic                    det_hit,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [CNT_W-1:0]        rsp_count
);

   localparam int               BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

   logic [2:0]        state_q, state_d;
   logic [ID_W-1:0]   ptr_q,   ptr_d;
   logic [WORD_W-1:0] word_q,  word_d;
   logic [ID_W-1:0]   id_q,    id_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [BIT_W-1:0]  bit_q,   bit_d;

   logic [N_REQ-1:0]  w_grant;
   logic [ID_W-1:0]   w_idx;
   logic              w_any;
   logic [WORD_W-1:0] w_word;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (w_grant),
      .idx_o   (w_idx),
      .any_o   (w_any)
   );

   always_comb begin
      w_word = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_idx == ID_W'(i)) begin
            w_word = req_data[i*WORD_W +: WORD_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      word_d  = word_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      case (state_q)
         ST_IDLE: begin
            if (w_any) begin
               word_d  = w_word;
               id_d    = w_idx;
               ptr_d   = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            cnt_d   = '0;
            bit_d   = LAST_BIT;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            // First SHIFT cycle still shows the hit output of the cleared detector.
            if (bit_q != LAST_BIT) begin
               cnt_d = cnt_q + CNT_W'(det_hit);
            end
            word_d = {word_q[WORD_W-2:0], 1'b0};
            if (bit_q == '0) begin
               state_d = ST_DRAIN;
            end else begin
               bit_d = bit_q - 1'b1;
            end
         end
         ST_DRAIN: begin
            cnt_d   = cnt_q + CNT_W'(det_hit);
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         word_q  <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         word_q  <= word_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
      end
   end

   // Grant is gated by rst so the combinational IDLE path is quiet during reset.
   assign req_ready = (state_q == ST_IDLE && !rst) ? w_grant : '0;
   assign det_rst   = (state_q == ST_CLEAR);
   assign det_in    = (state_q == ST_SHIFT) ? word_q[WORD_W-1] : 1'b0;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_id    = id_q;
   assign rsp_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_o_detect_sched.sv
// ============================================================================
// Module : tb_o_detect_sched
// Brief  : Directed bench for o_detect_sched with a Moore 0111 detector model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_o_detect_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [63:0] req_data;
   logic [3:0]  req_ready;
   logic        det_rst;
   logic        det_in;
   logic        det_hit;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [4:0]  rsp_count;

   int checks   = 0;
   int failures = 0;

   logic       tr_rst [0:63];
   logic       tr_in  [0:63];
   logic [3:0] tr_rdy [0:63];

   o_detect_sched #(
      .N_REQ  (4),
      .WORD_W (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .det_rst   (det_rst),
      .det_in    (det_in),
      .det_hit   (det_hit),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_count (rsp_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Moore 0111 detector, non-overlapping: state 4 is the hit state.
   logic [2:0] det_st;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         det_st <= 3'd0;
      end else if (det_rst) begin
         det_st <= 3'd0;
      end else begin
         case (det_st)
            3'd0:    det_st <= det_in ? 3'd0 : 3'd1;
            3'd1:    det_st <= det_in ? 3'd2 : 3'd1;
            3'd2:    det_st <= det_in ? 3'd3 : 3'd1;
            3'd3:    det_st <= det_in ? 3'd4 : 3'd1;
            default: det_st <= det_in ? 3'd0 : 3'd1;
         endcase
      end
   end
   assign det_hit = (det_st == 3'd4);

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(output logic [3:0] g);
      g = '0;
      for (int c = 0; c < 40; c++) begin
         if (req_ready != 4'b0000) begin
            g = req_ready;
            break;
         end
         tick();
      end
   endtask

   // Cycle count from grant cycle to first rsp_valid; traces recorded per cycle.
   task automatic wait_rsp(input bit drop, output int lat);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (drop && c == 1) begin
            req_valid = 4'b0000;
            #1;
         end
         tr_rst[c] = det_rst;
         tr_in[c]  = det_in;
         tr_rdy[c] = req_ready;
         if (rsp_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   logic [3:0]  g;
   int          lat;
   int          nrst;
   int          nvalid;
   logic [15:0] ser;
   logic [3:0]  rr_exp_g [0:4];
   logic [4:0]  rr_exp_c [0:4];

   initial begin
      rst       = 1'b1;
      req_valid = 4'b0001;
      req_data  = '0;
      rsp_ready = 1'b1;
      tick();
      tick();
      chk("reset_req_ready", req_ready, 4'b0000);
      chk("reset_rsp_valid", rsp_valid, 1'b0);
      chk("reset_det_rst",   det_rst,   1'b0);
      chk("reset_det_in",    det_in,    1'b0);
      chk("reset_rsp_id",    rsp_id,    2'd0);
      chk("reset_rsp_count", rsp_count, 5'd0);
      req_valid = 4'b0000;
      rst = 1'b0;
      tick();

      // Single job on requester 0
      req_data  = {48'h0, 16'h7777};
      req_valid = 4'b0001;
      #1;
      wait_grant(g);
      chk("single_grant", g, 4'b0001);
      wait_rsp(1'b1, lat);
      chk("single_ready_one_cycle", tr_rdy[1], 4'b0000);
      chk("single_latency", lat, 19);
      chk("single_id", rsp_id, 2'd0);
      chk("single_count", rsp_count, 5'd4);
      tick();
      chk("single_rsp_done", rsp_valid, 1'b0);

      // Zero hits on requester 2; det_rst exactly one cycle before the bits
      req_data  = 64'h0;
      req_valid = 4'b0100;
      #1;
      wait_grant(g);
      chk("zero_grant", g, 4'b0100);
      wait_rsp(1'b1, lat);
      nrst = 0;
      for (int c = 1; c <= lat; c++) nrst += int'(tr_rst[c]);
      chk("zero_det_rst_first", tr_rst[1], 1'b1);
      chk("zero_det_rst_cycles", nrst, 1);
      chk("zero_id", rsp_id, 2'd2);
      chk("zero_count", rsp_count, 5'd0);
      tick();

      // Serialisation of 16'h8001 on requester 1
      req_data  = {32'h0, 16'h8001, 16'h0};
      req_valid = 4'b0010;
      #1;
      wait_grant(g);
      chk("ser_grant", g, 4'b0010);
      wait_rsp(1'b1, lat);
      for (int k = 0; k < 16; k++) ser[15-k] = tr_in[2+k];
      chk("ser_bits", ser, 16'h8001);
      chk("ser_clear_in", tr_in[1], 1'b0);
      chk("ser_drain_in", tr_in[18], 1'b0);
      chk("ser_id", rsp_id, 2'd1);
      chk("ser_count", rsp_count, 5'd0);
      tick();

      // Mixed pattern on requester 3: three hits
      req_data  = {16'h0E77, 48'h0};
      req_valid = 4'b1000;
      #1;
      wait_grant(g);
      chk("mix_grant", g, 4'b1000);
      wait_rsp(1'b1, lat);
      chk("mix_id", rsp_id, 2'd3);
      chk("mix_count", rsp_count, 5'd3);
      tick();

      // Round-robin with all four requesters held valid
      rr_exp_g[0] = 4'b0001; rr_exp_c[0] = 5'd4;
      rr_exp_g[1] = 4'b0010; rr_exp_c[1] = 5'd3;
      rr_exp_g[2] = 4'b0100; rr_exp_c[2] = 5'd2;
      rr_exp_g[3] = 4'b1000; rr_exp_c[3] = 5'd1;
      rr_exp_g[4] = 4'b0001; rr_exp_c[4] = 5'd4;
      req_data  = {16'h0700, 16'h0077, 16'h0E77, 16'h7777};
      req_valid = 4'b1111;
      #1;
      for (int j = 0; j < 5; j++) begin
         wait_grant(g);
         chk($sformatf("rr_grant_%0d", j), g, rr_exp_g[j]);
         wait_rsp(1'b0, lat);
         chk($sformatf("rr_latency_%0d", j), lat, 19);
         chk($sformatf("rr_id_%0d", j), rsp_id, (j == 4) ? 2'd0 : 2'(j));
         chk($sformatf("rr_count_%0d", j), rsp_count, rr_exp_c[j]);
         if (j == 4) req_valid = 4'b0000;
         tick();
      end

      // Backpressure: response held for 10 cycles, pending request not granted
      rsp_ready = 1'b0;
      req_data  = {16'h0, 16'h0077, 16'h0, 16'h7777};
      req_valid = 4'b0001;
      #1;
      wait_grant(g);
      chk("bp_grant", g, 4'b0001);
      wait_rsp(1'b1, lat);
      chk("bp_latency", lat, 19);
      for (int c = 0; c < 10; c++) begin
         req_valid = 4'b0100;
         tick();
         chk("bp_valid_hold", rsp_valid, 1'b1);
         chk("bp_id_hold", rsp_id, 2'd0);
         chk("bp_count_hold", rsp_count, 5'd4);
         chk("bp_no_grant", req_ready, 4'b0000);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_handshake_no_grant", req_ready, 4'b0000);
      tick();
      chk("bp_after_valid", rsp_valid, 1'b0);
      chk("bp_after_grant", req_ready, 4'b0100);
      wait_grant(g);
      wait_rsp(1'b1, lat);
      chk("bp_next_id", rsp_id, 2'd2);
      chk("bp_next_count", rsp_count, 5'd2);
      tick();

      // Reset mid-SHIFT aborts the job and clears the pointer
      req_data  = {32'h0, 16'hFFFF, 16'h0};
      req_valid = 4'b0010;
      #1;
      wait_grant(g);
      chk("abort_grant", g, 4'b0010);
      tick();
      req_valid = 4'b0000;
      for (int c = 0; c < 4; c++) tick();
      chk("abort_pre_det_in", det_in, 1'b1);
      rst = 1'b1;
      #1;
      chk("abort_det_in", det_in, 1'b0);
      chk("abort_det_rst", det_rst, 1'b0);
      chk("abort_rsp_valid", rsp_valid, 1'b0);
      chk("abort_rsp_id", rsp_id, 2'd0);
      chk("abort_rsp_count", rsp_count, 5'd0);
      chk("abort_req_ready", req_ready, 4'b0000);
      tick();
      tick();
      rst = 1'b0;
      nvalid = 0;
      for (int c = 0; c < 25; c++) begin
         tick();
         nvalid += int'(rsp_valid);
      end
      chk("abort_no_rsp", nvalid, 0);
      req_data  = {32'h0, 16'h7777, 16'h0};
      req_valid = 4'b0110;
      #1;
      wait_grant(g);
      chk("abort_ptr_reset_grant", g, 4'b0010);
      wait_rsp(1'b1, lat);
      chk("abort_next_id", rsp_id, 2'd1);
      chk("abort_next_count", rsp_count, 5'd4);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
